// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory controller between the RV32I core data port and a
// word-wide single-port synchronous RAM without byte enables.
// Byte/half stores are done as read-modify-write on the full word.
// Optional build macro: DMEM_ERR_EN (misaligned/illegal access reporting).
//
// Handshake: a request is taken on any rising edge where cpu_req && cpu_ready.
// cpu_ready is high only in IDLE. cpu_req is ignored while busy. Each accepted
// request produces exactly one cpu_rvalid pulse, with cpu_rdata/cpu_err valid
// in that same cycle. cpu_rdata holds its value until the next completion.
//
// dbg_state encoding: 0 IDLE, 1 RD, 2 WAIT, 3 WR, 4 RESP.
module dmem_ctrl #(
  parameter int ADDR_W  = 15,
  parameter int RAM_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [2:0]        cpu_op,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_rvalid,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_err,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WAIT = 3'd2,
    S_WR   = 3'd3,
    S_RESP = 3'd4
  } state_t;

  localparam int CNT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [2:0]       op_q;
  logic             we_q;
  logic [1:0]       lane_q;
  logic [15:0]      wdata_q;
  logic             acc_err;

  // Address bits above the RAM word index alias onto the same words.
  logic unused_addr_hi;
  assign unused_addr_hi = ^cpu_addr[31:ADDR_W+2];

  assign dbg_state = state;

  // Little-endian lane extraction with sign/zero extension from func3.
  function automatic logic [31:0] load_extract(input logic [31:0] w,
                                               input logic [2:0]  op,
                                               input logic [1:0]  lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'(w >> {lane, 3'b000});
    h = lane[1] ? w[31:16] : w[15:0];
    case (op[1:0])
      2'b00:   r = op[2] ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   r = op[2] ? {16'd0, h} : {{16{h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Replace the addressed byte/half of the word read back from RAM.
  function automatic logic [31:0] store_merge(input logic [31:0] w,
                                              input logic [2:0]  op,
                                              input logic [1:0]  lane,
                                              input logic [15:0] wd);
    logic [31:0] r;
    r = w;
    if (op[1:0] == 2'b00) begin
      case (lane)
        2'd0:    r[7:0]   = wd[7:0];
        2'd1:    r[15:8]  = wd[7:0];
        2'd2:    r[23:16] = wd[7:0];
        default: r[31:24] = wd[7:0];
      endcase
    end else if (lane[1]) begin
      r[31:16] = wd;
    end else begin
      r[15:0] = wd;
    end
    return r;
  endfunction

`ifdef DMEM_ERR_EN
  logic illegal_op;
  logic misaligned;
  logic err_q;

  // Classify the incoming request as illegal or misaligned.
  always_comb begin
    illegal_op = (cpu_op == 3'b011) || (cpu_op[2:1] == 2'b11) ||
                 (cpu_we && cpu_op[2]);
    misaligned = ((cpu_op[1:0] == 2'b01) && cpu_addr[0]) ||
                 ((cpu_op[1:0] == 2'b10) && (cpu_addr[1:0] != 2'b00));
    acc_err    = illegal_op || misaligned;
  end

  // Error flag is high only in the RESP cycle that follows an erroring accept.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= cpu_ready && cpu_req && acc_err;
  end

  assign cpu_err = err_q;
`else
  assign acc_err = 1'b0;
  assign cpu_err = 1'b0;
`endif

  // Main sequencer: state, captured request and all registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      op_q       <= 3'd0;
      we_q       <= 1'b0;
      lane_q     <= 2'd0;
      wdata_q    <= 16'd0;
      cpu_ready  <= 1'b1;
      cpu_rvalid <= 1'b0;
      cpu_rdata  <= 32'd0;
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cpu_req) begin
            op_q      <= cpu_op;
            we_q      <= cpu_we;
            lane_q    <= cpu_addr[1:0];
            wdata_q   <= cpu_wdata[15:0];
            ram_addr  <= cpu_addr[ADDR_W+1:2];
            cpu_ready <= 1'b0;
            if (acc_err) begin
              state      <= S_RESP;
              cpu_rvalid <= 1'b1;
              cpu_rdata  <= 32'd0;
            end else if (cpu_we && cpu_op[1]) begin
              // Full-word store needs no read-back.
              state     <= S_WR;
              ram_en    <= 1'b1;
              ram_we    <= 1'b1;
              ram_wdata <= cpu_wdata;
            end else begin
              state  <= S_RD;
              ram_en <= 1'b1;
            end
          end
        end
        S_RD: begin
          state    <= S_WAIT;
          ram_en   <= 1'b0;
          wait_cnt <= CNT_W'(RAM_LAT - 1);
        end
        S_WAIT: begin
          if (wait_cnt == '0) begin
            if (we_q) begin
              state     <= S_WR;
              ram_en    <= 1'b1;
              ram_we    <= 1'b1;
              ram_wdata <= store_merge(ram_rdata, op_q, lane_q, wdata_q);
            end else begin
              state      <= S_RESP;
              cpu_rvalid <= 1'b1;
              cpu_rdata  <= load_extract(ram_rdata, op_q, lane_q);
            end
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end
        S_WR: begin
          state      <= S_RESP;
          ram_en     <= 1'b0;
          ram_we     <= 1'b0;
          cpu_rvalid <= 1'b1;
          cpu_rdata  <= 32'd0;
        end
        S_RESP: begin
          state      <= S_IDLE;
          cpu_rvalid <= 1'b0;
          cpu_ready  <= 1'b1;
        end
        default: begin
          state      <= S_IDLE;
          cpu_rvalid <= 1'b0;
          cpu_ready  <= 1'b1;
          ram_en     <= 1'b0;
          ram_we     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: drives two controllers (RAM_LAT=1 on unit 0, RAM_LAT=3 on
// unit 1), each attached to its own behavioural RAM, and checks them against
// a word-level reference memory with load/store rules computed arithmetically.
module tb_dmem_ctrl;

  localparam int ADDR_W = 15;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              req    [2];
  logic              we_s   [2];
  logic [2:0]        op_s   [2];
  logic [31:0]       addr_s [2];
  logic [31:0]       wd_s   [2];
  logic              ready  [2];
  logic              rvalid [2];
  logic [31:0]       rdata  [2];
  logic              err    [2];
  logic              ram_en [2];
  logic              ram_we [2];
  logic [ADDR_W-1:0] ram_addr  [2];
  logic [31:0]       ram_wdata [2];
  logic [31:0]       ram_rdata [2];
  logic [2:0]        dbg    [2];

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] ref_mem [2][32];
  logic [31:0] mem0 [0:32767];
  logic [31:0] mem1 [0:32767];
  logic [31:0] p1a, p1b;

  // Clock generation
  always #5 clock = ~clock;

  dmem_ctrl #(.ADDR_W(ADDR_W), .RAM_LAT(1)) dut0 (
    .clock(clock), .reset(reset),
    .cpu_req(req[0]), .cpu_we(we_s[0]), .cpu_op(op_s[0]),
    .cpu_addr(addr_s[0]), .cpu_wdata(wd_s[0]),
    .cpu_ready(ready[0]), .cpu_rvalid(rvalid[0]), .cpu_rdata(rdata[0]),
    .cpu_err(err[0]), .ram_en(ram_en[0]), .ram_we(ram_we[0]),
    .ram_addr(ram_addr[0]), .ram_wdata(ram_wdata[0]),
    .ram_rdata(ram_rdata[0]), .dbg_state(dbg[0])
  );

  dmem_ctrl #(.ADDR_W(ADDR_W), .RAM_LAT(3)) dut1 (
    .clock(clock), .reset(reset),
    .cpu_req(req[1]), .cpu_we(we_s[1]), .cpu_op(op_s[1]),
    .cpu_addr(addr_s[1]), .cpu_wdata(wd_s[1]),
    .cpu_ready(ready[1]), .cpu_rvalid(rvalid[1]), .cpu_rdata(rdata[1]),
    .cpu_err(err[1]), .ram_en(ram_en[1]), .ram_we(ram_we[1]),
    .ram_addr(ram_addr[1]), .ram_wdata(ram_wdata[1]),
    .ram_rdata(ram_rdata[1]), .dbg_state(dbg[1])
  );

  // RAM with 1-cycle read latency; garbage on the bus when no read was issued
  always @(posedge clock) begin
    if (ram_en[0] && ram_we[0]) mem0[ram_addr[0]] <= ram_wdata[0];
    if (ram_en[0] && !ram_we[0]) ram_rdata[0] <= mem0[ram_addr[0]];
    else                         ram_rdata[0] <= 32'hA5A5_5A5A;
  end

  // RAM with 3-cycle read latency
  always @(posedge clock) begin
    if (ram_en[1] && ram_we[1]) mem1[ram_addr[1]] <= ram_wdata[1];
    if (ram_en[1] && !ram_we[1]) p1a <= mem1[ram_addr[1]];
    else                         p1a <= 32'hA5A5_5A5A;
    p1b          <= p1a;
    ram_rdata[1] <= p1b;
  end

  function automatic logic [31:0] mem_word(input int u, input int w);
    return (u == 0) ? mem0[w] : mem1[w];
  endfunction

  function automatic int op_size(input logic [2:0] op);
    if (op[1:0] == 2'b00) return 1;
    if (op[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [2:0] op,
                                             input logic [1:0] lane);
    logic [31:0] v;
    if (op_size(op) == 1) begin
      v = (w >> (8 * lane)) & 32'hFF;
      if (!op[2] && v[7]) v = v | 32'hFFFF_FF00;
    end else if (op_size(op) == 2) begin
      v = (w >> (16 * lane[1])) & 32'hFFFF;
      if (!op[2] && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] w, input logic [2:0] op,
                                              input logic [1:0] lane, input logic [31:0] wd);
    logic [31:0] mask;
    if (op_size(op) == 1) begin
      mask = 32'hFF << (8 * lane);
      return (w & ~mask) | ((wd & 32'hFF) << (8 * lane));
    end else if (op_size(op) == 2) begin
      mask = 32'hFFFF << (16 * lane[1]);
      return (w & ~mask) | ((wd & 32'hFFFF) << (16 * lane[1]));
    end
    return wd;
  endfunction

  function automatic logic model_err(input logic we, input logic [2:0] op, input logic [31:0] addr);
`ifdef DMEM_ERR_EN
    logic ill;
    logic mis;
    ill = (op == 3'd3) || (op == 3'd6) || (op == 3'd7) || (we && op >= 3'd4);
    mis = (op_size(op) == 2 && addr[0]) || (op_size(op) == 4 && addr[1:0] != 2'b00);
    return ill || mis;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int model_lat(input int u, input logic we, input logic [2:0] op,
                                   input logic [31:0] addr);
    int l;
    l = (u == 0) ? 1 : 3;
    if (model_err(we, op, addr)) return 1;
    if (!we) return 2 + l;
    if (op_size(op) == 4) return 2;
    return 3 + l;
  endfunction

  // One complete transaction; returns response, latency, strobe count and strobe trace
  task automatic access(input int u, input logic we, input logic [2:0] op,
                        input logic [31:0] addr, input logic [31:0] wd, input bit noise,
                        output logic [31:0] rd, output logic er, output int lat,
                        output int en_cnt, output logic [15:0] trace);
    int guard;
    guard = 0;
    @(negedge clock);
    while (ready[u] !== 1'b1 && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    req[u] = 1'b1; we_s[u] = we; op_s[u] = op; addr_s[u] = addr; wd_s[u] = wd;
    @(negedge clock);
    req[u] = 1'b0; we_s[u] = 1'($urandom); op_s[u] = 3'($urandom);
    addr_s[u] = $urandom; wd_s[u] = $urandom;
    lat = 1; en_cnt = 0; trace = 16'd0;
    while (1) begin
      en_cnt += int'(ram_en[u]);
      trace = {trace[13:0], ram_en[u], ram_we[u]};
      if (rvalid[u] === 1'b1 || lat >= 20) break;
      if (noise) req[u] = 1'($urandom_range(0, 1));
      @(negedge clock);
      lat++;
    end
    req[u] = 1'b0;
    rd = rdata[u];
    er = err[u];
  endtask

  task automatic test_reset();
    for (int u = 0; u < 2; u++) begin
      n_tests++;
      if (ready[u] !== 1'b1 || rvalid[u] !== 1'b0 || err[u] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hs u%0d: ready=%b rvalid=%b err=%b required 1 0 0", u, ready[u], rvalid[u], err[u]);
      end
      n_tests++;
      if (ram_en[u] !== 1'b0 || ram_we[u] !== 1'b0 || dbg[u] !== 3'd0) begin
        n_fail++;
        $display("FAIL reset_ram u%0d: en=%b we=%b state=%0d required 0 0 0", u, ram_en[u], ram_we[u], dbg[u]);
      end
      n_tests++;
      if (rdata[u] !== 32'd0 || ram_addr[u] !== '0 || ram_wdata[u] !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_data u%0d: rdata=%h addr=%h wdata=%h required 0", u, rdata[u], ram_addr[u], ram_wdata[u]);
      end
    end
  endtask

  task automatic test_sw_lw();
    logic [31:0] rd; logic er; int lat, en; logic [15:0] tr;
    access(0, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 1'b0, rd, er, lat, en, tr);
    ref_mem[0][4] = 32'hDEAD_BEEF;
    n_tests++;
    if (lat !== 2 || rd !== 32'd0 || er !== 1'b0) begin
      n_fail++;
      $display("FAIL sw: lat=%0d rdata=%h err=%b required 2 0 0", lat, rd, er);
    end
    n_tests++;
    if (mem0[4] !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL sw_mem: word4=%h required deadbeef", mem0[4]);
    end
    access(0, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, rd, er, lat, en, tr);
    n_tests++;
    if (lat !== 3 || rd !== 32'hDEAD_BEEF || er !== 1'b0 || en !== 1) begin
      n_fail++;
      $display("FAIL lw: lat=%0d rdata=%h err=%b strobes=%0d required 3 deadbeef 0 1", lat, rd, er, en);
    end
  endtask

  task automatic test_sb_merge();
    logic [31:0] rd; logic er; int lat, en; logic [15:0] tr;
    access(0, 1'b1, 3'b000, 32'h11, 32'h0000_0055, 1'b0, rd, er, lat, en, tr);
    ref_mem[0][4] = 32'hDEAD_55EF;
    n_tests++;
    if (lat !== 4 || tr !== 16'h008C) begin
      n_fail++;
      $display("FAIL sb_seq: lat=%0d trace=%h required 4 008c", lat, tr);
    end
    n_tests++;
    if (mem0[4] !== 32'hDEAD_55EF) begin
      n_fail++;
      $display("FAIL sb_mem: word4=%h required dead55ef", mem0[4]);
    end
  endtask

  task automatic test_loads();
    logic [31:0] rd; logic er; int lat, en; logic [15:0] tr;
    logic [2:0]  ops  [5];
    logic [31:0] adrs [5];
    logic [31:0] exps [5];
    ops[0] = 3'b000; adrs[0] = 32'h12;        exps[0] = 32'hFFFF_FF81;
    ops[1] = 3'b100; adrs[1] = 32'h12;        exps[1] = 32'h0000_0081;
    ops[2] = 3'b001; adrs[2] = 32'h12;        exps[2] = 32'hFFFF_8081;
    ops[3] = 3'b101; adrs[3] = 32'h10;        exps[3] = 32'h0000_F0FF;
    ops[4] = 3'b010; adrs[4] = 32'h0002_0010; exps[4] = 32'h8081_F0FF;
    access(0, 1'b1, 3'b010, 32'h10, 32'h8081_F0FF, 1'b0, rd, er, lat, en, tr);
    ref_mem[0][4] = 32'h8081_F0FF;
    for (int i = 0; i < 5; i++) begin
      access(0, 1'b0, ops[i], adrs[i], 32'h0, 1'b0, rd, er, lat, en, tr);
      n_tests++;
      if (rd !== exps[i] || er !== 1'b0 || lat !== 3) begin
        n_fail++;
        $display("FAIL load%0d op=%b addr=%h: rdata=%h err=%b lat=%0d required %h 0 3", i, ops[i], adrs[i], rd, er, lat, exps[i]);
      end
    end
  endtask

  task automatic test_err();
    logic [31:0] rd; logic er; int lat, en; logic [15:0] tr;
    access(0, 1'b0, 3'b010, 32'h13, 32'h0, 1'b0, rd, er, lat, en, tr);
`ifdef DMEM_ERR_EN
    n_tests++;
    if (lat !== 1 || er !== 1'b1 || rd !== 32'd0 || en !== 0) begin
      n_fail++;
      $display("FAIL err_lw: lat=%0d err=%b rdata=%h strobes=%0d required 1 1 0 0", lat, er, rd, en);
    end
    access(0, 1'b1, 3'b001, 32'h11, 32'h1234, 1'b0, rd, er, lat, en, tr);
    n_tests++;
    if (er !== 1'b1 || en !== 0 || mem0[4] !== ref_mem[0][4]) begin
      n_fail++;
      $display("FAIL err_sh: err=%b strobes=%0d word4=%h required 1 0 %h", er, en, mem0[4], ref_mem[0][4]);
    end
    access(0, 1'b0, 3'b011, 32'h10, 32'h0, 1'b0, rd, er, lat, en, tr);
    n_tests++;
    if (er !== 1'b1 || rd !== 32'd0 || lat !== 1) begin
      n_fail++;
      $display("FAIL err_op: err=%b rdata=%h lat=%0d required 1 0 1", er, rd, lat);
    end
`else
    n_tests++;
    if (lat !== 3 || er !== 1'b0 || rd !== ref_mem[0][4]) begin
      n_fail++;
      $display("FAIL mis_lw: lat=%0d err=%b rdata=%h required 3 0 %h", lat, er, rd, ref_mem[0][4]);
    end
`endif
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat, en; logic [15:0] tr;
    logic seen_rvalid;
    int guard;
    access(0, 1'b1, 3'b010, 32'h14, 32'h1122_3344, 1'b0, rd, er, lat, en, tr);
    ref_mem[0][5] = 32'h1122_3344;
    guard = 0;
    @(negedge clock);
    while (ready[0] !== 1'b1 && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    req[0] = 1'b1; we_s[0] = 1'b1; op_s[0] = 3'b000; addr_s[0] = 32'h15; wd_s[0] = 32'hAA;
    @(negedge clock);
    req[0] = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    n_tests++;
    if (dbg[0] !== 3'd0 || ram_en[0] !== 1'b0 || ready[0] !== 1'b1 || rvalid[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid: state=%0d en=%b ready=%b rvalid=%b required 0 0 1 0", dbg[0], ram_en[0], ready[0], rvalid[0]);
    end
    seen_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (i == 1) reset = 1'b1;
      seen_rvalid = seen_rvalid | rvalid[0] | ram_en[0];
    end
    n_tests++;
    if (seen_rvalid !== 1'b0 || mem0[5] !== 32'h1122_3344) begin
      n_fail++;
      $display("FAIL rst_after: stray=%b word5=%h required 0 11223344", seen_rvalid, mem0[5]);
    end
    access(0, 1'b0, 3'b010, 32'h14, 32'h0, 1'b0, rd, er, lat, en, tr);
    n_tests++;
    if (rd !== 32'h1122_3344 || lat !== 3) begin
      n_fail++;
      $display("FAIL rst_resume: rdata=%h lat=%0d required 11223344 3", rd, lat);
    end
  endtask

  task automatic test_lat3();
    logic [31:0] rd; logic er; int lat, en; logic [15:0] tr;
    access(1, 1'b1, 3'b010, 32'h18, 32'hCAFE_F00D, 1'b1, rd, er, lat, en, tr);
    ref_mem[1][6] = 32'hCAFE_F00D;
    n_tests++;
    if (lat !== 2 || en !== 1 || mem1[6] !== 32'hCAFE_F00D) begin
      n_fail++;
      $display("FAIL l3_sw: lat=%0d strobes=%0d word6=%h required 2 1 cafef00d", lat, en, mem1[6]);
    end
    access(1, 1'b0, 3'b010, 32'h18, 32'h0, 1'b1, rd, er, lat, en, tr);
    n_tests++;
    if (lat !== 5 || en !== 1 || tr !== 16'h0200 || rd !== 32'hCAFE_F00D) begin
      n_fail++;
      $display("FAIL l3_lw: lat=%0d strobes=%0d trace=%h rdata=%h required 5 1 0200 cafef00d", lat, en, tr, rd);
    end
    @(negedge clock);
    n_tests++;
    if (ready[1] !== 1'b1 || ram_en[1] !== 1'b0 || rvalid[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL l3_idle: ready=%b en=%b rvalid=%b required 1 0 0", ready[1], ram_en[1], rvalid[1]);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd; logic er; int lat, en; logic [15:0] tr;
    logic [31:0] addr, wd, exp_rd;
    logic [2:0]  op;
    logic        we, exp_er;
    int          w, exp_lat;
    for (int u = 0; u < 2; u++) begin
      for (int k = 8; k < 16; k++) begin
        wd = $urandom;
        access(u, 1'b1, 3'b010, 32'(k * 4), wd, 1'b0, rd, er, lat, en, tr);
        ref_mem[u][k] = wd;
      end
      for (int i = 0; i < 40; i++) begin
        w    = $urandom_range(8, 15);
        op   = 3'($urandom_range(0, 7));
        we   = 1'($urandom_range(0, 1));
        wd   = $urandom;
        addr = ($urandom & 32'hFFFE_0000) | 32'(w * 4) | 32'($urandom_range(0, 3));
        exp_er  = model_err(we, op, addr);
        exp_lat = model_lat(u, we, op, addr);
        exp_rd  = (we || exp_er) ? 32'd0 : model_load(ref_mem[u][w], op, addr[1:0]);
        if (we && !exp_er) ref_mem[u][w] = model_store(ref_mem[u][w], op, addr[1:0], wd);
        access(u, we, op, addr, wd, 1'($urandom_range(0, 1)), rd, er, lat, en, tr);
        n_tests++;
        if (rd !== exp_rd || er !== exp_er || lat !== exp_lat || mem_word(u, w) !== ref_mem[u][w]) begin
          n_fail++;
          $display("FAIL rand u%0d #%0d we=%b op=%b addr=%h: rdata=%h err=%b lat=%0d word=%h required %h %b %0d %h",
                   u, i, we, op, addr, rd, er, lat, mem_word(u, w), exp_rd, exp_er, exp_lat, ref_mem[u][w]);
        end
      end
    end
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      req[u] = 1'b0; we_s[u] = 1'b0; op_s[u] = 3'd0; addr_s[u] = 32'd0; wd_s[u] = 32'd0;
    end
    reset = 1'b0;
    repeat (3) @(negedge clock);
    test_reset();
    reset = 1'b1;
    @(negedge clock);
    test_reset();
    test_sw_lw();
    test_sb_merge();
    test_loads();
    test_err();
    test_reset_mid();
    test_lat3();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Time bound for the whole run
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
